// File: rtl/writeback_regfile.sv
// writeback_regfile: WB-stage result select, 32x integer register file
// with two async read ports, and a committed-write counter.
//
// Ports:
//   clk, reset            - pipeline clock, synchronous active-high reset
//   regWrite_WB           - commit enable from MEM/WB
//   resultSrc_WB          - 00 ALU, 01 load, 10 PC+4, 11 immediate
//   ALUResult_WB, loadOut_WB, PCPlus4_WB, immOut_WB - result sources
//   writeAddress_WB       - destination register index
//   readAddress1/2_ID     - decode read indices
//   readData1/2_ID        - decode read data (x0 always 0)
//   result_WB             - selected result, also the forwarding source
//   writeCount            - committed non-x0 writes, wraps silently
//
// Build option: define WB_BYPASS_EN to make a same-cycle read of the
// register being committed return result_WB (write-through). Without it
// the read returns the old array contents.
module writeback_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   regWrite_WB,
    input  logic [1:0]             resultSrc_WB,
    input  logic [DATA_WIDTH-1:0]  ALUResult_WB,
    input  logic [DATA_WIDTH-1:0]  loadOut_WB,
    input  logic [DATA_WIDTH-1:0]  immOut_WB,
    input  logic [DATA_WIDTH-1:0]  PCPlus4_WB,
    input  logic [4:0]             writeAddress_WB,
    input  logic [4:0]             readAddress1_ID,
    input  logic [4:0]             readAddress2_ID,
    output logic [DATA_WIDTH-1:0]  readData1_ID,
    output logic [DATA_WIDTH-1:0]  readData2_ID,
    output logic [DATA_WIDTH-1:0]  result_WB,
    output logic [COUNT_WIDTH-1:0] writeCount
);

    logic [DATA_WIDTH-1:0] regs [0:31];
    logic                  commit;

    always_comb begin
        result_WB = ALUResult_WB;
        unique case (resultSrc_WB)
            2'b00: result_WB = ALUResult_WB;
            2'b01: result_WB = loadOut_WB;
            2'b10: result_WB = PCPlus4_WB;
            2'b11: result_WB = immOut_WB;
            default: result_WB = ALUResult_WB;
        endcase
    end

    // Reset blocks the commit so reset always wins over a concurrent write.
    assign commit = regWrite_WB && (writeAddress_WB != 5'd0) && !reset;

    // Entry 0 is cleared by reset and never written, so it stays 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            writeCount <= '0;
        end else if (commit) begin
            regs[writeAddress_WB] <= result_WB;
            writeCount            <= writeCount + 1'b1;
        end
    end

    always_comb begin
        readData1_ID = '0;
        readData2_ID = '0;
        if (readAddress1_ID != 5'd0) begin
            readData1_ID = regs[readAddress1_ID];
        end
        if (readAddress2_ID != 5'd0) begin
            readData2_ID = regs[readAddress2_ID];
        end
`ifdef WB_BYPASS_EN
        // commit already excludes x0 and reset, so no extra guard here.
        if (commit && (readAddress1_ID == writeAddress_WB)) begin
            readData1_ID = result_WB;
        end
        if (commit && (readAddress2_ID == writeAddress_WB)) begin
            readData2_ID = result_WB;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed checks of writeback_regfile with a
// 4-bit write counter so the wrap case is reachable.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite_WB;
    logic [1:0]  resultSrc_WB;
    logic [31:0] ALUResult_WB;
    logic [31:0] loadOut_WB;
    logic [31:0] immOut_WB;
    logic [31:0] PCPlus4_WB;
    logic [4:0]  writeAddress_WB;
    logic [4:0]  readAddress1_ID;
    logic [4:0]  readAddress2_ID;
    logic [31:0] readData1_ID;
    logic [31:0] readData2_ID;
    logic [31:0] result_WB;
    logic [3:0]  writeCount;

    int n_chk = 0;
    int n_pass = 0;

    writeback_regfile #(
        .DATA_WIDTH (32),
        .COUNT_WIDTH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .regWrite_WB    (regWrite_WB),
        .resultSrc_WB   (resultSrc_WB),
        .ALUResult_WB   (ALUResult_WB),
        .loadOut_WB     (loadOut_WB),
        .immOut_WB      (immOut_WB),
        .PCPlus4_WB     (PCPlus4_WB),
        .writeAddress_WB(writeAddress_WB),
        .readAddress1_ID(readAddress1_ID),
        .readAddress2_ID(readAddress2_ID),
        .readData1_ID   (readData1_ID),
        .readData2_ID   (readData2_ID),
        .result_WB      (result_WB),
        .writeCount     (writeCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mux_exp [0:3];
    logic [31:0] hz_exp;

    initial begin
        mux_exp[0] = 32'h11;
        mux_exp[1] = 32'h22;
        mux_exp[2] = 32'h33;
        mux_exp[3] = 32'h44;
`ifdef WB_BYPASS_EN
        hz_exp = 32'hCAFEF00D;
`else
        hz_exp = 32'h1;
`endif
        reset           = 1'b1;
        regWrite_WB     = 1'b0;
        resultSrc_WB    = 2'b00;
        ALUResult_WB    = '0;
        loadOut_WB      = '0;
        immOut_WB       = '0;
        PCPlus4_WB      = '0;
        writeAddress_WB = '0;
        readAddress1_ID = '0;
        readAddress2_ID = '0;
        step();
        reset = 1'b0;
        readAddress1_ID = 5'd5;
        readAddress2_ID = 5'd31;
        #1;
        chk("rst_rd1", readData1_ID, 32'h0);
        chk("rst_rd2", readData2_ID, 32'h0);
        chk("rst_cnt", {28'h0, writeCount}, 32'd0);

        // garbage into x5, then reset clears it
        regWrite_WB     = 1'b1;
        writeAddress_WB = 5'd5;
        ALUResult_WB    = 32'h12345678;
        step();
        regWrite_WB = 1'b0;
        #1;
        chk("x5_written", readData1_ID, 32'h12345678);
        chk("x5_cnt", {28'h0, writeCount}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("x5_after_rst", readData1_ID, 32'h0);
        chk("cnt_after_rst", {28'h0, writeCount}, 32'd0);

        // source mux sweep into x3
        ALUResult_WB    = 32'h11;
        loadOut_WB      = 32'h22;
        PCPlus4_WB      = 32'h33;
        immOut_WB       = 32'h44;
        writeAddress_WB = 5'd3;
        regWrite_WB     = 1'b1;
        for (int s = 0; s < 4; s++) begin
            resultSrc_WB = 2'(s);
            #1;
            chk($sformatf("mux_src%0d", s), result_WB, mux_exp[s]);
            step();
        end
        regWrite_WB     = 1'b0;
        readAddress1_ID = 5'd3;
        readAddress2_ID = 5'd3;
        #1;
        chk("x3_rd1", readData1_ID, 32'h44);
        chk("x3_rd2", readData2_ID, 32'h44);
        chk("mux_cnt", {28'h0, writeCount}, 32'd4);

        // x0 guard
        resultSrc_WB    = 2'b00;
        ALUResult_WB    = 32'hDEADBEEF;
        writeAddress_WB = 5'd0;
        regWrite_WB     = 1'b1;
        readAddress1_ID = 5'd0;
        #1;
        chk("x0_same_cycle", readData1_ID, 32'h0);
        step();
        regWrite_WB     = 1'b0;
        readAddress2_ID = 5'd0;
        #1;
        chk("x0_rd1", readData1_ID, 32'h0);
        chk("x0_rd2", readData2_ID, 32'h0);
        chk("x0_cnt", {28'h0, writeCount}, 32'd4);

        // same-cycle hazard on x7
        writeAddress_WB = 5'd7;
        ALUResult_WB    = 32'h1;
        regWrite_WB     = 1'b1;
        step();
        ALUResult_WB    = 32'hCAFEF00D;
        readAddress1_ID = 5'd7;
        readAddress2_ID = 5'd7;
        #1;
        chk("hz_rd1", readData1_ID, hz_exp);
        chk("hz_rd2", readData2_ID, hz_exp);
        step();
        regWrite_WB = 1'b0;
        #1;
        chk("hz_next_rd1", readData1_ID, 32'hCAFEF00D);
        chk("hz_next_rd2", readData2_ID, 32'hCAFEF00D);
        chk("hz_cnt", {28'h0, writeCount}, 32'd6);

        // reset vs commit on x9; reset also suppresses bypass
        reset           = 1'b1;
        regWrite_WB     = 1'b1;
        writeAddress_WB = 5'd9;
        ALUResult_WB    = 32'h55;
        readAddress1_ID = 5'd9;
        #1;
        chk("rst_no_bypass", readData1_ID, 32'h0);
        step();
        reset       = 1'b0;
        regWrite_WB = 1'b0;
        #1;
        chk("rst_vs_commit_x9", readData1_ID, 32'h0);
        chk("rst_vs_commit_x7", readData2_ID, 32'h0);
        chk("rst_vs_commit_cnt", {28'h0, writeCount}, 32'd0);

        // back-to-back commits to x2, last edge wins
        writeAddress_WB = 5'd2;
        regWrite_WB     = 1'b1;
        ALUResult_WB    = 32'hAAAA0001;
        step();
        ALUResult_WB = 32'hBBBB0002;
        step();
        regWrite_WB     = 1'b0;
        readAddress1_ID = 5'd2;
        readAddress2_ID = 5'd1;
        #1;
        chk("b2b_x2", readData1_ID, 32'hBBBB0002);
        chk("b2b_x1", readData2_ID, 32'h0);
        chk("b2b_cnt", {28'h0, writeCount}, 32'd2);

        // counter wrap: 17 commits to x1 on a 4-bit counter
        reset = 1'b1;
        step();
        reset           = 1'b0;
        writeAddress_WB = 5'd1;
        regWrite_WB     = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ALUResult_WB = 32'(i);
            step();
        end
        regWrite_WB = 1'b0;
        #1;
        chk("wrap_cnt", {28'h0, writeCount}, 32'd1);
        chk("wrap_x1", readData2_ID, 32'd16);
        chk("wrap_x2_cleared", readData1_ID, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
